// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, widths and helpers for the UART TX arbiter
package uart_arb_pkg;

    // Arbiter state: idle (waiting for any request) or a frame-locked grant
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_e;

    // Stall counter width; the counter saturates instead of wrapping
    localparam int TMO_CNT_W = 16;

    // Ceiling log2, used to size requester index and pointer fields
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
    parameter int P_NUM   = 4,
    parameter int P_IDX_W = 2
) (
    input  logic [P_NUM-1:0]   i_req,
    input  logic [P_IDX_W-1:0] i_ptr,
    output logic [P_NUM-1:0]   o_grant,
    output logic [P_IDX_W-1:0] o_idx,
    output logic               o_any
);

    // Scan from the pointer upward with wrap; the first active request wins
    always_comb begin
        int                 pos;
        logic [P_IDX_W-1:0] sel;
        pos     = 0;
        sel     = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < P_NUM; i++) begin
            pos = int'(i_ptr) + i;
            if (pos >= P_NUM) begin
                pos = pos - P_NUM;
            end
            sel = P_IDX_W'(pos);
            if (!o_any && i_req[sel]) begin
                o_any        = 1'b1;
                o_grant[sel] = 1'b1;
                o_idx        = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-locked round-robin arbiter for one UART TX channel (option: UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int P_REQ_NUM      = 4,
    parameter int P_DATA_WIDTH   = 8,
    parameter int P_IDLE_TIMEOUT = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_REQ_NUM-1:0]              i_req_valid,
    input  logic [P_REQ_NUM-1:0]              i_req_last,
    output logic [P_REQ_NUM-1:0]              o_req_ready,
    output logic [P_DATA_WIDTH-1:0]           o_tx_data,
    output logic                              o_tx_valid,
    input  logic                              i_tx_ready,
    output logic [P_REQ_NUM-1:0]              o_grant,
    output logic                              o_busy,
    output logic                              o_timeout
);

    localparam int IDX_W = clog2(P_REQ_NUM);

    if (P_REQ_NUM < 2 || P_REQ_NUM > 8) begin : g_bad_req_num
        $error("uart_tx_arbiter: P_REQ_NUM must be 2..8");
    end
    if (P_IDLE_TIMEOUT < 1 || P_IDLE_TIMEOUT > 65535) begin : g_bad_timeout
        $error("uart_tx_arbiter: P_IDLE_TIMEOUT must be 1..65535");
    end

    arb_state_e                state_q, state_d;
    logic [P_REQ_NUM-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [P_DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      timeout_q, timeout_d;

    logic [P_REQ_NUM-1:0]      pick_grant;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;

    logic                      load_en;
    logic                      up_beat;
    logic                      own_valid;
    logic                      own_last;
    logic [P_DATA_WIDTH-1:0]   own_data;
    logic [IDX_W-1:0]          next_ptr;
    logic                      cnt_hit;

    rr_pick #(
        .P_NUM   (P_REQ_NUM),
        .P_IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (ptr_q),
        .o_grant (pick_grant),
        .o_idx   (pick_idx),
        .o_any   (pick_any)
    );

    // Owner-side view of the request bus and the single-entry output handshake
    always_comb begin
        own_valid = i_req_valid[idx_q];
        own_last  = i_req_last[idx_q];
        own_data  = i_req_data[int'(idx_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
        load_en   = !tx_valid_q || i_tx_ready;
        up_beat   = (state_q == S_GRANT) && own_valid && load_en;
        next_ptr  = (idx_q == IDX_W'(P_REQ_NUM - 1)) ? '0 : idx_q + 1'b1;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(P_IDLE_TIMEOUT);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    // Count owner stall cycles; an accepted beat or leaving the grant clears it
    always_comb begin
        cnt_d   = cnt_q;
        cnt_hit = 1'b0;
        if (state_q != S_GRANT || up_beat) begin
            cnt_d = '0;
        end else if (!own_valid) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == TMO_LIMIT) begin
                cnt_hit = 1'b1;
                cnt_d   = '0;
            end
        end
    end

    // Stall counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign cnt_hit = 1'b0;
`endif

    // Grant FSM: pick on idle, release on the owner's last beat or a stall abort
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d = S_GRANT;
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                end
            end
            S_GRANT: begin
                if (up_beat && own_last) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else if (cnt_hit) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                end
            end
        endcase
    end

    // Output register: load on an upstream beat, drain on a downstream beat
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (up_beat) begin
            tx_data_d  = own_data;
            tx_valid_d = 1'b1;
        end else if (i_tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any pending byte
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_req_ready = grant_q & {P_REQ_NUM{load_en}};
    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q == S_GRANT) || tx_valid_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [N*W-1:0]   i_req_data  = '0;
    logic [N-1:0]     i_req_valid = '0;
    logic [N-1:0]     i_req_last  = '0;
    logic [N-1:0]     o_req_ready;
    logic [W-1:0]     o_tx_data;
    logic             o_tx_valid;
    logic             i_tx_ready;
    logic [N-1:0]     o_grant;
    logic             o_busy;
    logic             o_timeout;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] rq [N][$];
    logic [7:0] line_q [$];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .P_REQ_NUM      (N),
        .P_DATA_WIDTH   (W),
        .P_IDLE_TIMEOUT (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_data  (i_req_data),
        .i_req_valid (i_req_valid),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    // Requesters present the head of their byte queue, refreshed mid-cycle
    always @(negedge clk) begin
        for (int n = 0; n < N; n++) begin
            if (rq[n].size() > 0) begin
                i_req_valid[n]       = 1'b1;
                i_req_last[n]        = rq[n][0][8];
                i_req_data[n*W +: W] = rq[n][0][7:0];
            end else begin
                i_req_valid[n]       = 1'b0;
                i_req_last[n]        = 1'b0;
                i_req_data[n*W +: W] = '0;
            end
        end
    end

    // Pop accepted bytes and record every byte that leaves on the line
    always @(posedge clk) begin
        for (int n = 0; n < N; n++) begin
            if (i_req_valid[n] && o_req_ready[n] && rq[n].size() > 0) begin
                void'(rq[n].pop_front());
            end
        end
        if (!i_rst && o_tx_valid && i_tx_ready) begin
            line_q.push_back(o_tx_data);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((o_busy || rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_drain"}, 32'(k < 300), 32'd1);
    endtask

    task automatic check_line(input string tag);
        check({tag, "_len"}, line_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < line_q.size()) ? 32'(line_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        line_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int  k;
        logic seen;

        // Reset state
        i_rst      = 1'b1;
        i_tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_grant", o_grant, 4'b0000);
        check("rst_tx_valid", o_tx_valid, 1'b0);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_timeout", o_timeout, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ready", o_req_ready, 4'b0000);
        i_rst = 1'b0;

        // Single requester frame 55,AA,0D on req1
        rq[1].push_back({1'b0, 8'h55});
        rq[1].push_back({1'b0, 8'hAA});
        rq[1].push_back({1'b1, 8'h0D});
        @(negedge clk);
        check("t1_grant_pre", o_grant, 4'b0000);
        tick();
        check("t1_grant", o_grant, 4'b0010);
        check("t1_busy", o_busy, 1'b1);
        tick();
        check("t1_d0", o_tx_data, 8'h55);
        check("t1_v0", o_tx_valid, 1'b1);
        tick();
        check("t1_d1", o_tx_data, 8'hAA);
        tick();
        check("t1_d2", o_tx_data, 8'h0D);
        check("t1_grant_rel", o_grant, 4'b0000);
        check("t1_busy_tail", o_busy, 1'b1);
        tick();
        check("t1_v_end", o_tx_valid, 1'b0);
        check("t1_busy_end", o_busy, 1'b0);
        exp_q = '{8'h55, 8'hAA, 8'h0D};
        check_line("t1_line");

        // Pointer now 2: req3 beats req0
        rq[0].push_back({1'b1, 8'h0A});
        rq[3].push_back({1'b1, 8'h3A});
        @(negedge clk);
        tick();
        check("t2_grant", o_grant, 4'b1000);
        drain("t2");
        exp_q = '{8'h3A, 8'h0A};
        check_line("t2_line");

        // Reset pulse restores pointer 0
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;

        // Contention from pointer 0, then re-issued req0 wins over req1
        rq[0].push_back({1'b0, 8'h01});
        rq[0].push_back({1'b1, 8'h02});
        rq[2].push_back({1'b1, 8'h21});
        rq[3].push_back({1'b1, 8'h31});
        drain("t3a");
        rq[0].push_back({1'b1, 8'h03});
        rq[1].push_back({1'b1, 8'h11});
        drain("t3b");
        exp_q = '{8'h01, 8'h02, 8'h21, 8'h31, 8'h03, 8'h11};
        check_line("t3_line");

        // Backpressure for 10 cycles mid-frame
        for (int b = 0; b < 5; b++) begin
            rq[1].push_back({(b == 4), 8'(8'h81 + b)});
        end
        k = 0;
        while (line_q.size() < 2 && k < 50) begin
            tick();
            k++;
        end
        check("t4_start", 32'(k < 50), 32'd1);
        check("t4_held", o_tx_data, 8'h83);
        i_tx_ready = 1'b0;
        repeat (10) begin
            tick();
            check("t4_stable", o_tx_data, 8'h83);
            check("t4_valid", o_tx_valid, 1'b1);
            check("t4_ready", o_req_ready, 4'b0000);
        end
        i_tx_ready = 1'b1;
        drain("t4");
        exp_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
        check_line("t4_line");

        // Owner stalls mid-frame while req2 waits
        rq[1].push_back({1'b0, 8'h10});
        repeat (4) tick();
        rq[2].push_back({1'b1, 8'h20});
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (o_timeout) seen = 1'b1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        check("t5_timeout_seen", seen, 1'b1);
        check("t5_grant", o_grant, 4'b0000);
        rq[1].push_back({1'b1, 8'h11});
        drain("t5");
        exp_q = '{8'h10, 8'h20, 8'h11};
`else
        check("t5_timeout_seen", seen, 1'b0);
        check("t5_grant", o_grant, 4'b0010);
        check("t5_len_mid", line_q.size(), 1);
        rq[1].push_back({1'b1, 8'h11});
        drain("t5");
        exp_q = '{8'h10, 8'h11, 8'h20};
`endif
        check_line("t5_line");

        // Reset mid-frame with a byte held in the output register
        i_tx_ready = 1'b0;
        rq[3].push_back({1'b0, 8'h71});
        rq[3].push_back({1'b0, 8'h72});
        rq[3].push_back({1'b1, 8'h73});
        k = 0;
        while (!o_tx_valid && k < 20) begin
            tick();
            k++;
        end
        check("t6_loaded", 32'(k < 20), 32'd1);
        check("t6_grant_pre", o_grant, 4'b1000);
        i_rst = 1'b1;
        rq[3].delete();
        line_q.delete();
        tick();
        check("t6_tx_valid", o_tx_valid, 1'b0);
        check("t6_grant", o_grant, 4'b0000);
        check("t6_busy", o_busy, 1'b0);
        check("t6_timeout", o_timeout, 1'b0);
        i_rst      = 1'b0;
        i_tx_ready = 1'b1;
        rq[3].push_back({1'b1, 8'h7F});
        rq[1].push_back({1'b1, 8'h1F});
        @(negedge clk);
        tick();
        check("t6_regrant", o_grant, 4'b0010);
        drain("t6");
        exp_q = '{8'h1F, 8'h7F};
        check_line("t6_line");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, frame-locked arbiter that shares one UART transmit channel among P_REQ_NUM requesters, e.g. status reporter, capture-card register readback and debug echo.
- Sits in the user clock domain of the UART driver and drives its user TX valid/ready interface.
- A grant is held for a whole frame, delimited by a per-requester last flag, so bytes from different requesters never interleave on the line.

Parameters:
- P_REQ_NUM, 4, number of requesters, 2..8
- P_DATA_WIDTH, 8, byte width; must match the UART data width
- P_IDLE_TIMEOUT, 1024, stall cycles before a frame is aborted (used only with the optional feature), 1..65535

Ports:
- i_clk  in  1  UART user clock
- i_rst  in  1  reset; synchronous, active-high
- i_req_data  in  P_REQ_NUM*P_DATA_WIDTH  requester n byte at bits [n*P_DATA_WIDTH +: P_DATA_WIDTH]
- i_req_valid  in  P_REQ_NUM  per-requester byte valid
- i_req_last  in  P_REQ_NUM  per-requester last byte of frame; qualified by valid
- o_req_ready  out  P_REQ_NUM  per-requester ready
- o_tx_data  out  P_DATA_WIDTH  byte to the UART TX user interface
- o_tx_valid  out  1  byte valid to the UART
- i_tx_ready  in  1  UART TX ready
- o_grant  out  P_REQ_NUM  one-hot current owner; all zero when idle
- o_busy  out  1  high in S_GRANT or while o_tx_valid is high
- o_timeout  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset (synchronous, active-high, i_rst) forces:
  - state S_IDLE
  - o_grant=0, o_tx_valid=0, o_tx_data=0, o_timeout=0
  - round-robin pointer ptr=0
- Handshakes:
  - Upstream beat on requester n: i_req_valid[n] && o_req_ready[n].
  - Downstream beat: o_tx_valid && i_tx_ready.
- Output stage: one-entry register.
  - load_en = !o_tx_valid || i_tx_ready.
  - o_req_ready[n] = o_grant[n] && load_en (combinational); all other ready bits are 0.
  - On an upstream beat: o_tx_data is loaded and o_tx_valid goes to 1 on the next edge.
  - A downstream beat with no new load clears o_tx_valid.
  - o_tx_data is held stable while o_tx_valid && !i_tx_ready.
- S_IDLE:
  - If any i_req_valid is set, choose the first requester scanning from ptr upward (wrapping).
  - Register its one-hot grant and move to S_GRANT.
  - Arbitration latency is 1 cycle; the first byte is accepted at the earliest in the cycle after the request is seen.
  - With no request, stay in S_IDLE.
- S_GRANT:
  - Accept beats only from the granted requester.
  - An upstream beat with i_req_last set means: next state S_IDLE, o_grant=0, ptr=(granted index+1) mod P_REQ_NUM.
  - A new arbitration can then start while the last byte still waits in the output register.
- Boundary conditions:
  - Valid from non-granted requesters is ignored during S_GRANT; those requesters keep valid asserted (AXI-style rule: valid never drops without a beat).
  - Simultaneous requests: the lowest index at or above ptr wins; ptr wraps from P_REQ_NUM-1 to 0.
  - A single-byte frame (valid and last together) takes 1 grant cycle.
  - Granted valid deasserting mid-frame is legal: the grant is held indefinitely unless UART_ARB_TIMEOUT_EN is defined.
  - Reset mid-frame: the byte in the output register is discarded and the frame is lost with no partial flush.
- Width rules:
  - Index width is clog2(P_REQ_NUM).
  - Timeout counter width is 16 bits and saturates; it never wraps.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - In S_GRANT, a 16-bit counter increments on each cycle where the granted i_req_valid is 0 and clears on every accepted beat.
  - When it reaches P_IDLE_TIMEOUT: go to S_IDLE, advance ptr past the owner, pulse o_timeout for 1 cycle and clear the counter.
  - The output register contents are still delivered.
- Not defined: no counter is built, o_timeout is tied to 0, and the grant is held until last.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding S_IDLE=1'b0, S_GRANT=1'b1
  - function clog2
  - localparam for timeout counter width (16)
- One sub-module, rr_pick: combinational round-robin priority picker with inputs (req vector, ptr) and outputs (one-hot grant, index, any). It can be reused by future shared-resource arbiters.

Test Plan:
- Single requester, P_REQ_NUM=4: req1 sends frame 0x55,0xAA,0x0D (last on 0x0D) with i_tx_ready always 1 -> o_grant=4'b0010 one cycle after valid; o_tx_data sequence 55,AA,0D; ptr becomes 2; o_busy falls 1 cycle after the last downstream beat.
- Contention with ptr=0: req0 frame {0x01,0x02}, req2 frame {0x21}, req3 frame {0x31} all valid together -> line order 01,02,21,31 with no interleaving; a re-issued req0 after that wins next because ptr wrapped to 0.
- Backpressure: i_tx_ready held low 10 cycles mid-frame -> o_tx_data is stable and o_req_ready stays 0 for the whole window; no byte is lost or duplicated, checked against a scoreboard.
- Stalled owner with UART_ARB_TIMEOUT_EN and P_IDLE_TIMEOUT=16: req1 sends 0x10, then drops valid; req2 is waiting -> o_timeout pulses after exactly 16 idle cycles, then req2 is granted. Without the macro, req2 is never granted and o_timeout stays 0.
- Synchronous reset asserted during S_GRANT with o_tx_valid=1 -> on the next edge o_tx_valid=0, o_grant=0, state S_IDLE, and the next grant goes to the lowest-index requester (ptr=0).
- Random regression over 10k frames, 1..16 bytes each, random valid and ready -> per-requester byte order is preserved, frames never interleave, and every requester is granted within P_REQ_NUM-1 frames of requesting.
